pwm_sample_dac: RTL and testbench

Downstream stage of the function generator with frequency selector. Captures each 8-bit waveform sample on the rising edge of the generator's divided clock and turns it into a pulse-width-modulated bit stream on the fast system clock. An external RC filter rebuilds the analog waveform from that bit stream. A shadow/active register pair keeps every PWM period glitch-free and reports samples that arrive too fast.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_sample_dac_edge_sync.sv | 42 ++++
 rtl/pwm_sample_dac.sv | 108 ++++++++++
 tb/tb_pwm_sample_dac.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and shadow-register state encoding for the PWM sample DAC.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEF      = 8;
    localparam int unsigned PWM_PERIOD_MAX_DEF = 255;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_FULL  = 1'b1
    } shadow_state_e;

endpackage

// File: rtl/pwm_sample_dac_edge_sync.sv
// Rising-edge detector for the upstream divided clock; emits a one-cycle cap pulse.
// Define PWM_SAMPLE_SYNC_EN to insert a two-flop synchronizer ahead of the detector.
module edge_sync
    import pwm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_clk_i,
    output logic cap_o
);

`ifdef PWM_SAMPLE_SYNC_EN
    logic [1:0] sync_q;
    logic       hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sample_clk_i};
            hist_q <= sync_q[1];
        end
    end

    assign cap_o = sync_q[1] & ~hist_q;
`else
    logic hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sample_clk_i;
        end
    end

    // Raw input feeds the detector directly so the sample lands on the same edge.
    assign cap_o = sample_clk_i & ~hist_q;
`endif

endmodule

// File: rtl/pwm_sample_dac.sv
// PWM DAC: captures upstream samples into a shadow register and swaps them into the
// active duty only at period boundaries. Optional sync stage: PWM_SAMPLE_SYNC_EN.
module pwm_sample_dac
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = PWM_WIDTH_DEF,
    parameter int unsigned PERIOD_MAX = PWM_PERIOD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_clk,
    input  logic [WIDTH-1:0] sample,
    input  logic             ovr_clr,
    output logic             pwm_out,
    output logic             period_start,
    output logic             shadow_full,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] CNT_TERM = WIDTH'(PERIOD_MAX);

    logic             cap;
    logic             wrap;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    shadow_state_e    state_q, state_d;
    logic             ovr_q, ovr_d;
    logic             pwm_q;
    logic             ps_q;

    edge_sync u_edge_sync (
        .clk_i        (clk),
        .rst_ni       (rst),
        .sample_clk_i (sample_clk),
        .cap_o        (cap)
    );

    assign wrap = en & (cnt_q == CNT_TERM);

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        ovr_d    = ovr_q;

        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        // A capture coinciding with a wrap hands the old shadow over, so it is not an overrun.
        case (state_q)
            SH_EMPTY: begin
                if (cap) begin
                    shadow_d = sample;
                    state_d  = SH_FULL;
                end
            end
            SH_FULL: begin
                if (wrap) begin
                    active_d = shadow_q;
                end
                if (cap) begin
                    shadow_d = sample;
                    state_d  = SH_FULL;
                    if (!wrap) begin
                        ovr_d = 1'b1;
                    end
                end else if (wrap) begin
                    state_d = SH_EMPTY;
                end
            end
            default: state_d = SH_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            active_q <= '0;
            shadow_q <= '0;
            state_q  <= SH_EMPTY;
            ovr_q    <= 1'b0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            ovr_q    <= ovr_d;
            pwm_q    <= en & (cnt_q < active_q);
            ps_q     <= en & (cnt_q == '0);
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign shadow_full  = (state_q == SH_FULL);
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_pwm_sample_dac.sv
// Bench for pwm_sample_dac: two instances (PERIOD_MAX 255 and 99) on shared stimulus,
// checked every cycle against a period/pending-sample model plus literal duty counts.
module tb_pwm_sample_dac;

`ifdef PWM_SAMPLE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       sclk = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] smp = 8'd0;
    logic [1:0] pwm, ps, sf, ov;

    int total = 0;
    int bad = 0;
    int pmax[2] = '{255, 99};

    always #5 clk = ~clk;

    pwm_sample_dac #(.WIDTH(8), .PERIOD_MAX(255)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sample_clk(sclk), .sample(smp), .ovr_clr(ovr_clr),
        .pwm_out(pwm[0]), .period_start(ps[0]), .shadow_full(sf[0]), .overrun(ov[0])
    );

    pwm_sample_dac #(.WIDTH(8), .PERIOD_MAX(99)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sample_clk(sclk), .sample(smp), .ovr_clr(ovr_clr),
        .pwm_out(pwm[1]), .period_start(ps[1]), .shadow_full(sf[1]), .overrun(ov[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: position within the period, duty in force, at most one pending sample.
    int m_pos[2], m_duty[2], m_pval[2];
    bit m_pend[2], m_ovr[2], m_pwm[2], m_ps[2];
    bit h_last, h_s1, h_s2;

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; m_duty[i] = 0; m_pval[i] = 0;
            m_pend[i] = 0; m_ovr[i] = 0; m_pwm[i] = 0; m_ps[i] = 0;
        end
        h_last = 0; h_s1 = 0; h_s2 = 0;
    endfunction

    function automatic void m_step();
        bit cap, wrap, newovr;
`ifdef PWM_SAMPLE_SYNC_EN
        cap = h_s2 && !h_last;
        h_last = h_s2; h_s2 = h_s1; h_s1 = sclk;
`else
        cap = sclk && !h_last;
        h_last = sclk;
`endif
        for (int i = 0; i < 2; i++) begin
            wrap = en && (m_pos[i] == pmax[i]);
            m_pwm[i] = en && (m_pos[i] < m_duty[i]);
            m_ps[i] = en && (m_pos[i] == 0);
            newovr = cap && m_pend[i] && !wrap;
            if (wrap && m_pend[i]) begin
                m_duty[i] = m_pval[i];
                m_pend[i] = 0;
            end
            if (cap) begin
                m_pval[i] = int'(smp);
                m_pend[i] = 1;
            end
            if (en) m_pos[i] = wrap ? 0 : m_pos[i] + 1;
            if (newovr) m_ovr[i] = 1;
            else if (ovr_clr) m_ovr[i] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) m_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pwm_out[%0d]", i), int'(pwm[i]), int'(m_pwm[i]));
            chk($sformatf("period_start[%0d]", i), int'(ps[i]), int'(m_ps[i]));
            chk($sformatf("shadow_full[%0d]", i), int'(sf[i]), int'(m_pend[i]));
            chk($sformatf("overrun[%0d]", i), int'(ov[i]), int'(m_ovr[i]));
        end
        if (rst) m_step();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int v);
        smp = 8'(v);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic align();
        int k;
        k = 0;
        while (ps[0] !== 1'b1 && k < 600) begin
            tick(1);
            k++;
        end
        if (k >= 600) chk("align_timeout", 0, 1);
    endtask

    task automatic measure(input int i, input int skip, output int hi);
        int k;
        hi = 0;
        for (int s = 0; s <= skip; s++) begin
            k = 0;
            tick(1);
            while (ps[i] !== 1'b1 && k < 600) begin
                tick(1);
                k++;
            end
            if (k >= 600) chk("period_timeout", 0, 1);
        end
        for (int c = 0; c <= pmax[i]; c++) begin
            hi += int'(pwm[i]);
            tick(1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int hi, n;
        #1;
        for (int j = 0; j < 6; j++) begin
            sclk = ~sclk;
            tick(2);
        end
        for (int i = 0; i < 2; i++) begin
            chk("rst_pwm", int'(pwm[i]), 0);
            chk("rst_ps", int'(ps[i]), 0);
            chk("rst_sf", int'(sf[i]), 0);
            chk("rst_ovr", int'(ov[i]), 0);
        end

        rst = 1'b1;
        en = 1'b1;
        tick(1);
        chk("first_period_start", int'(ps[0]), 1);
        n = 0;
        hi = 0;
        for (int c = 0; c < 512; c++) begin
            tick(1);
            n += int'(ps[0]);
            hi += int'(pwm[0]);
        end
        chk("idle_ps_count_512", n, 2);
        chk("idle_pwm_high", hi, 0);

        align();
        capture(64);
        chk("sf_after_capture64", int'(sf[0]), 1);
        measure(0, 0, hi);
        chk("duty64", hi, 64);
        chk("sf_after_wrap", int'(sf[0]), 0);
        measure(0, 0, hi);
        chk("duty64_again", hi, 64);

        align();
        capture(0);
        measure(0, 0, hi);
        chk("duty0", hi, 0);
        align();
        capture(255);
        measure(0, 0, hi);
        chk("duty255", hi, 255);
        align();
        capture(200);
        measure(1, 1, hi);
        chk("p99_duty200", hi, 100);
        measure(0, 0, hi);
        chk("p255_duty200", hi, 200);

        align();
        capture(10);
        capture(20);
        chk("overrun_set", int'(ov[0]), 1);
        measure(0, 0, hi);
        chk("overrun_duty20", hi, 20);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("overrun_cleared", int'(ov[0]), 0);

        align();
        capture(30);
        smp = 8'd40;
        tick(248 - LAT);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(2);
        chk("wrapcap_full_sf", int'(sf[0]), 1);
        chk("wrapcap_full_no_ovr", int'(ov[0]), 0);
        measure(0, 0, hi);
        chk("wrapcap_full_duty40", hi, 40);

        align();
        smp = 8'd50;
        tick(254 - LAT);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(2);
        chk("wrapcap_empty_sf", int'(sf[0]), 1);
        measure(0, 0, hi);
        chk("wrapcap_empty_duty50", hi, 50);

        align();
        tick(10);
        en = 1'b0;
        tick(2);
        chk("en0_pwm", int'(pwm[0]), 0);
        chk("en0_ps", int'(ps[0]), 0);
        capture(77);
        chk("en0_capture_sf", int'(sf[0]), 1);
        tick(20);
        chk("en0_pwm_hold", int'(pwm[0]), 0);
        en = 1'b1;
        tick(3);
        chk("en1_resume_pwm", int'(pwm[0]), 1);
        measure(0, 0, hi);
        chk("duty77", hi, 77);

        tick(20);
        rst = 1'b0;
        #1;
        chk("midrst_pwm", int'(pwm[0]), 0);
        chk("midrst_sf", int'(sf[0]), 0);
        chk("midrst_ps", int'(ps[0]), 0);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("postrst_ps", int'(ps[0]), 1);
        measure(0, 0, hi);
        chk("postrst_duty0", hi, 0);

        for (int c = 0; c < 4000; c++) begin
            en = ($urandom_range(0, 15) != 0);
            ovr_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 59) == 0) begin
                sclk = ~sclk;
                if (sclk) smp = 8'($urandom);
            end
            if ($urandom_range(0, 1499) == 0) rst = 1'b0;
            else rst = 1'b1;
            tick(1);
        end
        rst = 1'b1;
        ovr_clr = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
